// File: rtl/cmsdk_ahb_to_apb_async_pkg.sv
// Shared definitions for the AHB side of the asynchronous AHB-to-APB bridge:
// FSM state encoding, AHB transfer/size codes and the byte-strobe decoder.
package cmsdk_ahb_to_apb_async_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ERR1  = 3'd3,
        ST_ERR2  = 3'd4
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Sizes wider than a word still address the whole 32-bit APB word.
    function automatic logic [3:0] byte_strobe(input logic [2:0] size,
                                               input logic [1:0] addr_lo);
        if (size == HSIZE_BYTE)
            return 4'b0001 << addr_lo;
        else if (size == HSIZE_HALF)
            return addr_lo[1] ? 4'b1100 : 4'b0011;
        else
            return 4'b1111;
    endfunction

endpackage

// File: rtl/cmsdk_ahb_to_apb_async_syn.sv
// Two-flop synchroniser used for the toggle handshake in both directions.
module cmsdk_ahb_to_apb_async_syn #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments keep meta and q as two distinct flops;
    // blocking ones would collapse the chain into a single stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cmsdk_ahb_to_apb_async_h.sv
// AHB-domain half of the asynchronous AHB-to-APB bridge: accepts AHB transfers
// and hands them to the APB domain over a toggle request/acknowledge handshake.
module cmsdk_ahb_to_apb_async_h
    import cmsdk_ahb_to_apb_async_pkg::*;
#(
    parameter int ADDRWIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HSEL,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic [3:0]           HPROT,
    input  logic                 HWRITE,
    input  logic                 HREADY,
    input  logic [31:0]          HWDATA,
    output logic                 HREADYOUT,
    output logic [31:0]          HRDATA,
    output logic                 HRESP,
    output logic                 s_req_h,
    input  logic                 s_ack_p,
    output logic [ADDRWIDTH-3:0] s_addr,
    output logic                 s_trans_valid,
    output logic [1:0]           s_prot,
    output logic [3:0]           s_strb,
    output logic                 s_write,
    output logic [31:0]          s_wdata,
    input  logic [31:0]          s_rdata,
    input  logic                 s_resp
);

    state_t state;
    logic   ack_sync;
    logic   accept;
    logic   done;

    cmsdk_ahb_to_apb_async_syn #(.WIDTH(1)) u_ack_syn (
        .clk (HCLK),
        .rst (HRESET),
        .d   (s_ack_p),
        .q   (ack_sync)
    );

    // Only the NONSEQ/SEQ bit of HTRANS matters; upper HPROT bits have no APB use.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, HTRANS[0], HPROT[3:2]};

    assign accept = HSEL & HTRANS[1] & HREADY & ((state == ST_IDLE) | (state == ST_ERR2));
    // The request has been serviced once the returning ack matches our toggle level.
    assign done   = (state == ST_WAIT) & (ack_sync == s_req_h);

    // NOTE: HREADYOUT and HRESP are updated together with every state change so
    // they are registered copies of the state decode rather than combinational.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state         <= ST_IDLE;
            HREADYOUT     <= 1'b1;
            HRESP         <= 1'b0;
            HRDATA        <= '0;
            s_req_h       <= 1'b0;
            s_trans_valid <= 1'b0;
            s_addr        <= '0;
            s_prot        <= '0;
            s_strb        <= '0;
            s_write       <= 1'b0;
            s_wdata       <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    HRESP <= 1'b0;
                    if (accept) begin
                        s_addr    <= HADDR[ADDRWIDTH-1:2];
                        s_write   <= HWRITE;
                        s_prot    <= {~HPROT[0], HPROT[1]};
                        s_strb    <= byte_strobe(HSIZE, HADDR[1:0]);
                        HREADYOUT <= 1'b0;
                        if (HWRITE) begin
                            state <= ST_WDATA;
                        end else begin
                            s_req_h       <= ~s_req_h;
                            s_trans_valid <= 1'b1;
                            state         <= ST_WAIT;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                    end
                end
                ST_WDATA: begin
                    s_wdata       <= HWDATA;
                    s_req_h       <= ~s_req_h;
                    s_trans_valid <= 1'b1;
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        s_trans_valid <= 1'b0;
                        if (!s_write)
                            HRDATA <= s_rdata;
                        if (s_resp) begin
                            state <= ST_ERR1;
                            HRESP <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            HREADYOUT <= 1'b1;
                        end
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmsdk_ahb_to_apb_async_h.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized transfers against a behavioural model of the bridge and APB side.
module tb_cmsdk_ahb_to_apb_async_h;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        s_req_h;
    logic        s_ack_p;
    logic [13:0] s_addr;
    logic        s_trans_valid;
    logic [1:0]  s_prot;
    logic [3:0]  s_strb;
    logic        s_write;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        s_resp;

    always #5 HCLK = ~HCLK;

    cmsdk_ahb_to_apb_async_h #(.ADDRWIDTH(16)) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .HSEL          (HSEL),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HSIZE         (HSIZE),
        .HPROT         (HPROT),
        .HWRITE        (HWRITE),
        .HREADY        (HREADY),
        .HWDATA        (HWDATA),
        .HREADYOUT     (HREADYOUT),
        .HRDATA        (HRDATA),
        .HRESP         (HRESP),
        .s_req_h       (s_req_h),
        .s_ack_p       (s_ack_p),
        .s_addr        (s_addr),
        .s_trans_valid (s_trans_valid),
        .s_prot        (s_prot),
        .s_strb        (s_strb),
        .s_write       (s_write),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata),
        .s_resp        (s_resp)
    );

    // APB-domain stand-in clocked by HCLK: sync the request, wait, then answer.
    int          apb_wait  = 0;
    logic [31:0] apb_rdata = '0;
    logic        apb_resp  = 1'b0;
    logic        req_m1, req_m2, apb_busy;
    int          apb_cnt;
    logic [13:0] cap_addr;
    logic [3:0]  cap_strb;
    logic [1:0]  cap_prot;
    logic        cap_write, cap_valid;
    logic [31:0] cap_wdata;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            req_m1   <= 1'b0;
            req_m2   <= 1'b0;
            apb_busy <= 1'b0;
            apb_cnt  <= 0;
            s_ack_p  <= 1'b0;
            s_rdata  <= '0;
            s_resp   <= 1'b0;
        end else begin
            req_m1 <= s_req_h;
            req_m2 <= req_m1;
            if (!apb_busy && (req_m2 != s_ack_p)) begin
                apb_busy <= 1'b1;
                apb_cnt  <= apb_wait;
            end else if (apb_busy) begin
                if (apb_cnt == 0) begin
                    apb_busy  <= 1'b0;
                    s_ack_p   <= ~s_ack_p;
                    s_rdata   <= apb_rdata;
                    s_resp    <= apb_resp;
                    cap_addr  <= s_addr;
                    cap_strb  <= s_strb;
                    cap_prot  <= s_prot;
                    cap_write <= s_write;
                    cap_wdata <= s_wdata;
                    cap_valid <= s_trans_valid;
                end else begin
                    apb_cnt <= apb_cnt - 1;
                end
            end
        end
    end

    // Counts every level change of s_req_h seen at a clock edge.
    logic prev_req;
    int   req_toggles = 0;
    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            prev_req <= 1'b0;
        end else begin
            if (s_req_h != prev_req)
                req_toggles <= req_toggles + 1;
            prev_req <= s_req_h;
        end
    end

    // Reference model state.
    logic [31:0] model_hrdata  = '0;
    int          model_toggles = 0;
    logic        model_req     = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic check_le(input string name, input int act, input int limit);
        n_checks++;
        if (act <= limit)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected <= %0d", name, act, limit);
    endtask

    function automatic logic [3:0] ref_strb(input logic [2:0] size, input logic [15:0] addr);
        int lane;
        lane = int'(addr) % 4;
        if (size == 3'd0) return 4'(1 << lane);
        if (size == 3'd1) return (lane >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    task automatic idle_bus();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HREADY = 1'b1;
    endtask

    task automatic start_xfer(input logic wr, input logic [15:0] addr,
                              input logic [2:0] size, input logic [3:0] prot);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        HSIZE  = size;
        HPROT  = prot;
        HREADY = 1'b1;
    endtask

    // One complete transfer; entered and left just after a rising edge in IDLE.
    task automatic ahb_xfer(input string tag, input logic wr, input logic [15:0] addr,
                            input logic [2:0] size, input logic [3:0] prot,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input logic resp, input int wait_cyc,
                            input logic [3:0] exp_strb, input logic [13:0] exp_saddr,
                            input logic [1:0] exp_prot);
        int   cycles, first_ready, err_cycles;
        logic fin, err1_ready, err2_ready;
        apb_rdata = rdata;
        apb_resp  = resp;
        apb_wait  = wait_cyc;
        start_xfer(wr, addr, size, prot);
        @(posedge HCLK); #1;
        idle_bus();
        HWDATA = wdata;
        cycles = 0; first_ready = 0; err_cycles = 0; fin = 1'b0;
        err1_ready = 1'b1; err2_ready = 1'b0;
        while (!fin && cycles < 60) begin
            @(negedge HCLK);
            cycles++;
            if (HRESP) begin
                err_cycles++;
                if (err_cycles == 1) err1_ready = HREADYOUT;
                if (err_cycles == 2) err2_ready = HREADYOUT;
            end
            if (HREADYOUT && first_ready == 0) first_ready = cycles;
            if (HREADYOUT && !HRESP) fin = 1'b1;
        end
        model_toggles++;
        model_req = ~model_req;
        if (!wr) model_hrdata = rdata;

        check({tag, "_done"},   32'(fin), 32'd1);
        check({tag, "_saddr"},  32'(cap_addr), 32'(exp_saddr));
        check({tag, "_strb"},   32'(cap_strb), 32'(exp_strb));
        check({tag, "_prot"},   32'(cap_prot), 32'(exp_prot));
        check({tag, "_write"},  32'(cap_write), 32'(wr));
        check({tag, "_valid"},  32'(cap_valid), 32'd1);
        if (wr) check({tag, "_wdata"}, cap_wdata, wdata);
        check({tag, "_hrdata"}, HRDATA, model_hrdata);
        check({tag, "_errcyc"}, 32'(err_cycles), resp ? 32'd2 : 32'd0);
        if (resp) begin
            check({tag, "_err1_rdy"}, 32'(err1_ready), 32'd0);
            check({tag, "_err2_rdy"}, 32'(err2_ready), 32'd1);
        end
        check({tag, "_toggles"}, 32'(req_toggles), 32'(model_toggles));
        check({tag, "_req"},     32'(s_req_h), 32'(model_req));
        check({tag, "_tvclr"},   32'(s_trans_valid), 32'd0);
        if (!wr && !resp && wait_cyc == 0) check_le({tag, "_latency"}, first_ready, 8);
        @(posedge HCLK); #1;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        resp;
        logic [3:0]  exp_strb;
        logic [13:0] exp_saddr;
        logic [1:0]  exp_prot;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          fin_cnt;
        logic        wr, resp;
        logic [15:0] addr;
        logic [2:0]  size;
        logic [3:0]  prot;

        vecs[0] = '{1'b0, 16'h0104, 3'd2, 4'b0011, 32'h0,        32'hCAFE0001, 1'b0, 4'b1111, 14'h0041, 2'b01};
        vecs[1] = '{1'b1, 16'h0003, 3'd0, 4'b0000, 32'h11223344, 32'h0,        1'b0, 4'b1000, 14'h0000, 2'b10};
        vecs[2] = '{1'b1, 16'h0002, 3'd1, 4'b0010, 32'hA5A50F0F, 32'h0,        1'b0, 4'b1100, 14'h0000, 2'b11};
        vecs[3] = '{1'b0, 16'hFFFD, 3'd0, 4'b0001, 32'h0,        32'h12345678, 1'b0, 4'b0010, 14'h3FFF, 2'b00};
        vecs[4] = '{1'b0, 16'h0010, 3'd3, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b1, 4'b1111, 14'h0004, 2'b10};
        vecs[5] = '{1'b1, 16'h8000, 3'd1, 4'b1111, 32'h01020304, 32'h0,        1'b1, 4'b0011, 14'h2000, 2'b01};
        vecs[6] = '{1'b0, 16'h0001, 3'd0, 4'b0000, 32'h0,        32'h0BADF00D, 1'b0, 4'b0010, 14'h0000, 2'b10};
        vecs[7] = '{1'b0, 16'h0006, 3'd1, 4'b0010, 32'h0,        32'h76543210, 1'b0, 4'b1100, 14'h0001, 2'b11};

        HRESET = 1'b1;
        idle_bus();
        HADDR = '0; HSIZE = '0; HPROT = '0; HWRITE = 1'b0; HWDATA = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp",     32'(HRESP), 32'd0);
        check("rst_hrdata",    HRDATA, 32'd0);
        check("rst_req",       32'(s_req_h), 32'd0);
        check("rst_tvalid",    32'(s_trans_valid), 32'd0);
        check("rst_s_outs",    {s_addr, s_strb, s_prot, s_write, 11'd0}, 32'd0);
        check("rst_wdata",     s_wdata, 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        for (int i = 0; i < 8; i++)
            ahb_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].size,
                     vecs[i].prot, vecs[i].wdata, vecs[i].rdata, vecs[i].resp, 0,
                     vecs[i].exp_strb, vecs[i].exp_saddr, vecs[i].exp_prot);

        // BUSY gets zero-wait OKAY; NONSEQ with HREADY low is not accepted.
        start_xfer(1'b0, 16'h0040, 3'd2, 4'd0);
        HTRANS = 2'b01;
        @(negedge HCLK);
        check("busy_ready", 32'({HREADYOUT, HRESP}), 32'b10);
        @(posedge HCLK); #1;
        HTRANS = 2'b10;
        HREADY = 1'b0;
        @(negedge HCLK);
        check("hready0_ready", 32'({HREADYOUT, HRESP}), 32'b10);
        @(posedge HCLK); #1;
        idle_bus();
        repeat (6) @(negedge HCLK);
        check("noaccept_toggles", 32'(req_toggles), 32'(model_toggles));
        check("noaccept_tvalid",  32'(s_trans_valid), 32'd0);
        @(posedge HCLK); #1;

        // Erroring read followed by a NONSEQ accepted during its ERR2 cycle.
        apb_rdata = 32'hAAAA0001; apb_resp = 1'b1; apb_wait = 0;
        start_xfer(1'b0, 16'h0020, 3'd2, 4'd0);
        @(posedge HCLK); #1;
        idle_bus();
        fin_cnt = 0;
        do begin
            @(negedge HCLK);
            fin_cnt++;
        end while (!(HREADYOUT && HRESP) && fin_cnt < 60);
        check("b2b_err2_seen", 32'({HREADYOUT, HRESP}), 32'b11);
        check("b2b_hrdata1",   HRDATA, 32'hAAAA0001);
        model_toggles++; model_req = ~model_req;
        apb_rdata = 32'h55550002; apb_resp = 1'b0;
        start_xfer(1'b0, 16'h0044, 3'd2, 4'd0);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        check("b2b_accepted", 32'({HREADYOUT, HRESP}), 32'b00);
        fin_cnt = 0;
        do begin
            @(negedge HCLK);
            fin_cnt++;
        end while (!(HREADYOUT && !HRESP) && fin_cnt < 60);
        model_toggles++; model_req = ~model_req; model_hrdata = 32'h55550002;
        check("b2b_done",    32'({HREADYOUT, HRESP}), 32'b10);
        check("b2b_hrdata2", HRDATA, model_hrdata);
        check("b2b_saddr",   32'(cap_addr), 32'h11);
        check("b2b_toggles", 32'(req_toggles), 32'(model_toggles));
        check("b2b_req",     32'(s_req_h), 32'(model_req));
        @(posedge HCLK); #1;

        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = 16'($urandom);
            size = 3'($urandom_range(0, 7));
            prot = 4'($urandom);
            resp = ($urandom_range(0, 3) == 0);
            ahb_xfer($sformatf("rnd%0d", i), wr, addr, size, prot, $urandom, $urandom,
                     resp, int'($urandom_range(0, 3)), ref_strb(size, addr), addr[15:2],
                     {~prot[0], prot[1]});
        end

        // Reset while waiting on a slow APB slave must abandon the transfer at once.
        apb_wait = 30; apb_rdata = 32'h99999999; apb_resp = 1'b0;
        start_xfer(1'b0, 16'h0100, 3'd2, 4'd0);
        @(posedge HCLK); #1;
        idle_bus();
        repeat (3) @(negedge HCLK);
        model_toggles++;
        check("wait_tvalid", 32'(s_trans_valid), 32'd1);
        check("wait_ready",  32'(HREADYOUT), 32'd0);
        #2 HRESET = 1'b1;
        #1;
        check("arst_ready",  32'({HREADYOUT, HRESP}), 32'b10);
        check("arst_tvalid", 32'(s_trans_valid), 32'd0);
        check("arst_req",    32'(s_req_h), 32'd0);
        check("arst_hrdata", HRDATA, 32'd0);
        model_req = 1'b0; model_hrdata = '0; apb_wait = 0;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(posedge HCLK); #1;
        ahb_xfer("post_rst", 1'b0, 16'h0208, 3'd2, 4'b0001, 32'h0, 32'h600DF00D, 1'b0, 0,
                 4'b1111, 14'h0082, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmsdk_ahb_to_apb_async_h.md
CMSDK_AHB_TO_APB_ASYNC_H -- requirements
Module: cmsdk_ahb_to_apb_async_h

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 16, the APB address width in bits.
REQ-002 SHALL have ports; clock HCLK, reset HRESET (asynchronous, active-high), one clock domain:
  HCLK  in  1  AHB clock
  HRESET  in  1  asynchronous active-high reset
  HSEL  in  1  slave select
  HADDR  in  ADDRWIDTH  AHB address
  HTRANS  in  2  transfer type
  HSIZE  in  3  transfer size
  HPROT  in  4  protection
  HWRITE  in  1  write flag
  HREADY  in  1  bus ready
  HWDATA  in  32  write data
  HREADYOUT  out  1  slave ready
  HRDATA  out  32  read data
  HRESP  out  1  error response
  s_req_h  out  1  toggle request to APB domain
  s_ack_p  in  1  toggle acknowledge from APB domain, unsynchronised
  s_addr  out  ADDRWIDTH-2  word address
  s_trans_valid  out  1  request genuinely pending
  s_prot  out  2  {~HPROT[0], HPROT[1]}
  s_strb  out  4  byte strobes
  s_write  out  1  write flag
  s_wdata  out  32  write data
  s_rdata  in  32  read data, stable after ack toggle
  s_resp  in  1  APB error, stable after ack toggle

Function
REQ-003 SHALL accept a transfer when HSEL & HTRANS[1] & HREADY in states IDLE or ERR2; IDLE/BUSY transfers SHALL get zero-wait OKAY.
REQ-004 SHALL use states IDLE, WDATA, WAIT, ERR1, ERR2; HREADYOUT = 1 in IDLE and ERR2, 0 otherwise; HRESP = 1 in ERR1 and ERR2 only.
REQ-005 On accepted read: register s_addr=HADDR[ADDRWIDTH-1:2], s_write, s_prot, s_strb; toggle s_req_h; set s_trans_valid; go WAIT.
REQ-006 On accepted write: register control as REQ-005, go WDATA; in WDATA register s_wdata=HWDATA, toggle s_req_h, set s_trans_valid, go WAIT.
REQ-007 s_strb: HSIZE 0 -> one-hot of HADDR[1:0]; 1 -> 0011 or 1100 by HADDR[1]; 2 or larger -> 1111.
REQ-008 SHALL synchronise s_ack_p through two HCLK flops before use; completion is the first WAIT cycle where synchronised ack equals s_req_h.
REQ-009 At completion SHALL clear s_trans_valid, capture HRDATA = s_rdata (reads), then go IDLE if s_resp=0 or ERR1 if s_resp=1; ERR1 -> ERR2 -> IDLE unconditionally.
REQ-010 HRDATA SHALL hold its value until the next read completion; s_addr/s_wdata/control SHALL stay stable while s_trans_valid=1.
REQ-011 Latency: read with PCLK=HCLK and a zero-wait APB slave SHALL complete (HREADYOUT=1) no later than 8 HCLK cycles after acceptance.

Reset
REQ-012 HRESET SHALL asynchronously force IDLE, s_req_h=0, ack sync flops=0, s_trans_valid=0, HRDATA=0, all s_* outputs=0, giving HREADYOUT=1, HRESP=0.
REQ-013 Reset mid-transfer SHALL abandon it; the APB domain SHALL be reset together (system rule).

Structure
REQ-014 State encodings, HTRANS and HSIZE constants SHALL live in shared package cmsdk_ahb_to_apb_async_pkg.
REQ-015 The two-flop synchroniser SHALL be sub-module cmsdk_ahb_to_apb_async_syn, also reused for the APB-side request sync.

Verification
REQ-016 Word read 0x0104, s_rdata=0xCAFE0001, s_resp=0 -> s_addr=0x41, s_strb=1111, HRDATA=0xCAFE0001, HRESP=0.
REQ-017 Byte write 0x0003 HWDATA=0x11223344 -> s_strb=1000, s_write=1, s_wdata=0x11223344, one s_req_h toggle.
REQ-018 Read with s_resp=1 -> HREADYOUT 0 then 1 with HRESP=1 for exactly two cycles, then OKAY.
REQ-019 New NONSEQ accepted in ERR2 cycle -> new transfer proceeds, no dropped or duplicate toggle.
REQ-020 HRESET asserted in WAIT -> HREADYOUT=1, s_trans_valid=0, s_req_h=0 immediately (asynchronously).
